// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives imemory, and hands fetched words to decode
// over valid/ready. It handles stalls, redirects with flush, and sticky misaligned-target faults.
module fetch_unit #(
  parameter int unsigned                ADDR_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic        [ADDR_WIDTH-1:0] RESET_PC = 32'h01000000,
  parameter int unsigned                PC_STEP    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_insn,
  output logic                  fault,
  output logic [31:0]           fetch_count
);

  // A mask is used instead of a bit slice so that PC_STEP == 1 still elaborates.
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'(PC_STEP - 1);
  localparam logic [ADDR_WIDTH-1:0] PcStep    = ADDR_WIDTH'(PC_STEP);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [DATA_WIDTH-1:0] out_insn_q, out_insn_d;
  logic [31:0]           fetch_count_q, fetch_count_d;

  logic misaligned;
  logic can_capture;

  assign misaligned  = (redirect_target & AlignMask) != '0;
  assign can_capture = !out_valid_q || out_ready;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (redirect_valid && misaligned) state_d = StFault;
      StFault: state_d = StFault;
      default: state_d = StRun;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_insn_d    = out_insn_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      StRun: begin
        if (redirect_valid) begin
          // Both redirect flavours flush; a misaligned target is kept in pc for debug.
          pc_d        = redirect_target;
          out_valid_d = 1'b0;
        end else if (can_capture) begin
          pc_d          = pc_q + PcStep;
          out_valid_d   = 1'b1;
          out_pc_d      = pc_q;
          out_insn_d    = imem_data;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      StFault: out_valid_d = 1'b0;
      default: out_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_insn_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_insn_q    <= out_insn_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Outputs.
  always_comb begin
    imem_addr   = pc_q;
    out_valid   = out_valid_q;
    out_pc      = out_pc_q;
    out_insn    = out_insn_q;
    fault       = (state_q == StFault);
    fetch_count = fetch_count_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_insn;
  logic        fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Memory returns word = address, so the held word must always equal the held PC.
  assign imem_data = imem_addr;

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_insn        (out_insn),
    .fault           (fault),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the next address to fetch, the instruction held for decode, and a tally.
  logic        m_known = 1'b0;
  logic [31:0] m_next_addr;
  logic        m_held;
  logic [31:0] m_held_pc;
  logic        m_stopped;
  logic [31:0] m_fetched;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_known     = 1'b1;
        m_next_addr = 32'h01000000;
        m_held      = 1'b0;
        m_stopped   = 1'b0;
        m_fetched   = 0;
      end else if (m_known && !m_stopped) begin
        if (redirect_valid) begin
          m_next_addr = redirect_target;
          m_held      = 1'b0;
          if (redirect_target % 4 != 0) m_stopped = 1'b1;
        end else if (!m_held || out_ready) begin
          m_held_pc   = m_next_addr;
          m_held      = 1'b1;
          m_next_addr = m_next_addr + 4;
          m_fetched   = m_fetched + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clock) begin
    if (m_known) begin
      chk("imem_addr", imem_addr, m_next_addr);
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_held});
      chk("fault", {31'b0, fault}, {31'b0, m_stopped});
      chk("fetch_count", fetch_count, m_fetched);
      if (m_held) begin
        chk("out_pc", out_pc, m_held_pc);
        chk("out_insn", out_insn, m_held_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    out_ready       = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    tick();
    tick();
    chk("rst_addr", imem_addr, 32'h01000000);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_insn", out_insn, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    reset = 1'b0;

    // Free run, then stall while 0x01000004 is held.
    tick();
    chk("run0_pc", out_pc, 32'h01000000);
    chk("run0_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("run1_pc", out_pc, 32'h01000004);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", out_pc, 32'h01000004);
      chk("stall_insn", out_insn, 32'h01000004);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_addr", imem_addr, 32'h01000008);
      chk("stall_count", fetch_count, 32'd2);
    end
    out_ready = 1'b1;
    tick();
    chk("run2_pc", out_pc, 32'h01000008);
    chk("run2_count", fetch_count, 32'd3);

    // Aligned redirect: one bubble.
    redirect_valid  = 1'b1;
    redirect_target = 32'h01000100;
    tick();
    redirect_valid = 1'b0;
    chk("redir_bubble", {31'b0, out_valid}, 32'd0);
    chk("redir_count", fetch_count, 32'd3);
    tick();
    chk("redir_pc0", out_pc, 32'h01000100);
    tick();
    chk("redir_pc1", out_pc, 32'h01000104);

    // Redirect while stalled drops the held instruction.
    out_ready       = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h02000000;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    chk("stredir_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("stredir_pc", out_pc, 32'h02000000);
    chk("stredir_count", fetch_count, 32'd6);

    // PC wrap.
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFFFFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_pc0", out_pc, 32'hFFFFFFFC);
    tick();
    chk("wrap_pc1", out_pc, 32'h00000000);
    chk("wrap_fault", {31'b0, fault}, 32'd0);

    // Misaligned redirect: sticky fault until reset.
    redirect_valid  = 1'b1;
    redirect_target = 32'h01000102;
    tick();
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_valid", {31'b0, out_valid}, 32'd0);
    chk("mis_addr", imem_addr, 32'h01000102);
    redirect_target = 32'h01000200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flt_fault", {31'b0, fault}, 32'd1);
      chk("flt_valid", {31'b0, out_valid}, 32'd0);
      chk("flt_addr", imem_addr, 32'h01000102);
      chk("flt_count", fetch_count, 32'd8);
    end
    redirect_valid = 1'b0;
    reset          = 1'b1;
    tick();
    reset = 1'b0;
    chk("clr_fault", {31'b0, fault}, 32'd0);
    chk("clr_addr", imem_addr, 32'h01000000);
    chk("clr_count", fetch_count, 32'd0);
    tick();
    chk("clr_pc", out_pc, 32'h01000000);

    // Random traffic; the per-cycle comparator does the checking.
    for (int i = 0; i < 4000; i++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0) redirect_target = $urandom();
      else redirect_target = $urandom() & 32'hFFFFFFFC;
      reset = ($urandom_range(0, 199) == 0) || (fault && $urandom_range(0, 7) == 0);
      tick();
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end that owns the program counter, drives the instruction memory, and presents fetched instructions to decode over a valid/ready handshake. It replaces the free-running "PC += 4" register in the top level. It adds back-pressure stalls, control-flow redirects with flush, misaligned-target fault detection and a fetch counter. It sits between `imemory` and the decode stage.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: width of the PC and memory address.
- `DATA_WIDTH`, default 32: instruction word width.
- `RESET_PC`, default 32'h01000000: PC loaded on reset.
- `PC_STEP`, default 4: PC increment per fetch. Must be a power of two. `ALIGN_BITS` = log2(`PC_STEP`).

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_addr` out `ADDR_WIDTH`: equals the `pc` register; drives `imemory` address.
- `imem_data` in `DATA_WIDTH`: `imemory` read data, valid combinationally in the same cycle as `imem_addr`.
- `redirect_valid` in 1: load a new PC this cycle.
- `redirect_target` in `ADDR_WIDTH`: new PC value.
- `out_valid` out 1: output register holds an instruction.
- `out_ready` in 1: decode accepts the instruction this cycle.
- `out_pc` out `ADDR_WIDTH`: PC of the held instruction.
- `out_insn` out `DATA_WIDTH`: held instruction word.
- `fault` out 1: sticky misaligned-redirect flag.
- `fetch_count` out 32: number of instructions captured since reset.

## Operation

- State machine with two states:
  - RUN: normal fetching.
  - FAULT: fetch stopped.
- `fire` = `out_valid` & `out_ready` (a handshake completes).
- `can_capture` = !`out_valid` | `out_ready`.
- Actions per edge in RUN, in priority order:
  1. **Redirect, misaligned.** `redirect_valid`=1 and `redirect_target[ALIGN_BITS-1:0]` != 0:
     - Go to FAULT with `fault`<=1 and `out_valid`<=0.
     - `pc` <= `redirect_target` (kept for debug).
     - No capture.
  2. **Redirect, aligned.** `redirect_valid`=1 and target aligned:
     - `pc` <= `redirect_target`; `out_valid`<=0 (flush).
     - No capture; `fetch_count` unchanged.
  3. **Capture.** `can_capture`=1:
     - `out_pc`<=`pc`, `out_insn`<=`imem_data`, `out_valid`<=1.
     - `pc` <= `pc` + `PC_STEP`, modulo 2^`ADDR_WIDTH` (wraps, no flag).
     - `fetch_count` <= `fetch_count` + 1, wrapping at 2^32.
  4. **Stall.** Otherwise: `pc`, `out_valid`, `out_pc` and `out_insn` all hold.
- Behaviour in FAULT:
  - `redirect_valid` and `out_ready` are ignored.
  - `out_valid`=0; `pc` and `fetch_count` hold.
  - Only `reset` leaves FAULT.
- `out_pc` and `out_insn` must stay stable while `out_valid`=1 and `out_ready`=0.

## Timing

- Reset values:
  - `pc`=`RESET_PC`, so `imem_addr`=`RESET_PC`.
  - `out_valid`=0, `out_pc`=0, `out_insn`=0.
  - `fault`=0, `fetch_count`=0, state RUN.
- Reset overrides every other input, including reset asserted in FAULT or mid-stall.
- Fetch latency: an address is presented in cycle N; its word appears on `out_*` after edge N+1.
- Throughput: one instruction per cycle while `out_ready`=1.
- Redirect costs exactly one bubble cycle:
  - Edge E: `pc`<=target, `out_valid`<=0.
  - Edge E+1: target's instruction is captured.
- Redirect together with `fire` in the same cycle: the current instruction counts as consumed, then the flush applies. Decode is not required to drop it.
- Redirect while stalled (`out_valid`=1, `out_ready`=0): the held instruction is discarded.
- `fault` and `out_valid`=0 are visible the cycle after the misaligned redirect edge.

## Test plan

- **Reset and free-run.** Hold `reset`=1 for 2 cycles, then release with `out_ready`=1 and memory returning word = address.
  - Expect `out_pc` = 0x01000000, 0x01000004, 0x01000008 on consecutive cycles.
  - Expect `fetch_count`=3 after the third capture.
- **Stall.** While `out_pc`=0x01000004, drive `out_ready`=0 for 3 cycles.
  - `out_valid`, `out_pc` and `out_insn` hold.
  - `imem_addr` holds 0x01000008; `fetch_count` is unchanged.
  - On release, 0x01000008 follows 0x01000004 with no loss or duplication.
- **Aligned redirect.** In steady run, pulse `redirect_valid` with target 0x01000100.
  - Next cycle: `out_valid`=0.
  - Following cycle: `out_pc`=0x01000100, then 0x01000104.
- **Redirect during stall.** Drive `out_ready`=0 and `redirect_valid`=1 with target 0x02000000.
  - The held instruction is dropped.
  - The next valid `out_pc` is 0x02000000.
- **Misaligned redirect.** Redirect to 0x01000102.
  - `fault`=1 and `out_valid`=0 from the next cycle.
  - Further redirects and `out_ready` have no effect.
  - Asserting `reset` clears `fault` and restarts fetch at 0x01000000.
- **Wrap.** Use `ADDR_WIDTH`=32 and redirect to 0xFFFFFFFC.
  - Captured `out_pc` sequence is 0xFFFFFFFC, then 0x00000000.
  - `fault` stays 0.
